param_readback_tx: RTL and testbench



---
 rtl/pulses_pkg.sv | 29 ++
 rtl/uart_tx_byte.sv | 100 ++++++++++
 rtl/param_readback_tx.sv | 158 +++++++++++++++
 tb/tb_param_readback_tx.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/pulses_pkg.sv
// Shared constants, state encodings and payload byte selection for the parameter readback link.
package pulses_pkg;

  localparam logic [7:0]  HEADER      = 8'hA5;
  localparam int unsigned FRAME_LEN   = 22;
  localparam int unsigned PAYLOAD_LEN = 20;
  localparam int unsigned PAYLOAD_W   = PAYLOAD_LEN * 8;
  localparam int unsigned BYTE_IDX_W  = 5;
  localparam int unsigned BIT_IDX_W   = 3;

  localparam int unsigned FLAG_PU  = 0;
  localparam int unsigned FLAG_NUT = 1;
  localparam int unsigned FLAG_BL  = 2;

  // Line-level phases of the serializer.
  typedef enum logic [2:0] {IDLE, ARM, START, DATA, STOP} state_t;

  // Frame-level sequencing in the top.
  typedef enum logic [1:0] {FRAME_IDLE, FRAME_ARM, FRAME_SEND} frame_state_t;

  // Payload byte idx (1..PAYLOAD_LEN) from the big-endian shadow; byte 1 is the MSB.
  function automatic logic [7:0] payload_byte(logic [PAYLOAD_W-1:0] shadow,
                                              logic [BYTE_IDX_W-1:0] idx);
    logic [PAYLOAD_W-1:0] sh;
    sh = shadow >> {5'(PAYLOAD_LEN) - idx, 3'b000};
    return sh[7:0];
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serializer, LSB first. ready is high when a start will be taken this cycle,
// including the last cycle of a stop bit so bytes can follow with no idle gap.
module uart_tx_byte
  import pulses_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1745
) (
  input  logic       clk_pll,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       ready,
  output logic       txd
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic [BIT_IDX_W-1:0]   bit_idx, bit_idx_n;
  logic [7:0]             shift, shift_n;
  logic                   txd_n, ready_n;
  logic                   bit_end;

  assign bit_end = (cnt == CNT_LAST);

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
      ready   <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      txd     <= txd_n;
      ready   <= ready_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    txd_n     = txd;
    if (state != IDLE) cnt_n = bit_end ? '0 : cnt + CNT_W'(1);
    case (state)
      IDLE: begin
        if (start) begin
          state_n = START;
          shift_n = data;
          txd_n   = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          state_n   = DATA;
          bit_idx_n = '0;
          txd_n     = shift[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_idx == BIT_IDX_W'(7)) begin
            state_n = STOP;
            txd_n   = 1'b1;
          end else begin
            bit_idx_n = bit_idx + BIT_IDX_W'(1);
            shift_n   = {1'b0, shift[7:1]};
            txd_n     = shift[1];
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          if (start) begin
            state_n = START;
            shift_n = data;
            txd_n   = 1'b0;
          end else begin
            state_n = IDLE;
            txd_n   = 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        txd_n   = 1'b1;
      end
    endcase
    ready_n = (state_n == IDLE) || ((state_n == STOP) && (cnt_n == CNT_LAST));
  end

endmodule

// File: rtl/param_readback_tx.sv
// Pulse parameter readback: snapshots the active parameter set and sends a 22-byte
// checksummed frame over UART. Optional READBACK_SYNC_ALIGN_EN delays the snapshot to a sync_on falling edge.
module param_readback_tx
  import pulses_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 1745,
  parameter logic [7:0]  HEADER       = pulses_pkg::HEADER
) (
  input  logic        clk_pll,
  input  logic        reset,
  input  logic        req,
  input  logic        sync_on,
  input  logic [7:0]  per,
  input  logic [15:0] p1wid,
  input  logic [15:0] del,
  input  logic [15:0] p2wid,
  input  logic [31:0] nut_w,
  input  logic [31:0] nut_d,
  input  logic [7:0]  cp,
  input  logic [7:0]  p_bl,
  input  logic [15:0] p_bl_off,
  input  logic        pu,
  input  logic        nut,
  input  logic        bl,
  output logic        txd,
  output logic        busy,
  output logic        done
);

  localparam logic [BYTE_IDX_W-1:0] BYTE_LAST = BYTE_IDX_W'(FRAME_LEN - 1);

  frame_state_t           state, state_n;
  logic                   busy_n, done_n;
  logic [BYTE_IDX_W-1:0]  byte_idx, byte_idx_n, byte_nxt_c;
  logic [7:0]             csum, csum_n;
  logic [PAYLOAD_W-1:0]   shadow, shadow_n, snap_c;
  logic [7:0]             flags_c, nxt_byte_c, ser_data_c;
  logic                   ser_start_c, ser_ready, load_c;

  always_comb begin
    flags_c           = '0;
    flags_c[FLAG_PU]  = pu;
    flags_c[FLAG_NUT] = nut;
    flags_c[FLAG_BL]  = bl;
  end

  assign snap_c = {per, p1wid, del, p2wid, nut_w, nut_d, cp, p_bl, p_bl_off, flags_c};

`ifdef READBACK_SYNC_ALIGN_EN
  logic sync_meta, sync_s, sync_d, sync_fall_c;

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_s    <= 1'b0;
      sync_d    <= 1'b0;
    end else begin
      sync_meta <= sync_on;
      sync_s    <= sync_meta;
      sync_d    <= sync_s;
    end
  end

  assign sync_fall_c = sync_d & ~sync_s;
`else
  logic unused_sync_on;
  assign unused_sync_on = sync_on;
`endif

  // Byte to hand the serializer when the current one finishes; the last slot carries the checksum.
  assign byte_nxt_c = byte_idx + BYTE_IDX_W'(1);
  assign nxt_byte_c = (byte_nxt_c == BYTE_LAST) ? csum : payload_byte(shadow, byte_nxt_c);

  always_ff @(posedge clk_pll or posedge reset) begin
    if (reset) begin
      state    <= FRAME_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      byte_idx <= '0;
      csum     <= '0;
      shadow   <= '0;
    end else begin
      state    <= state_n;
      busy     <= busy_n;
      done     <= done_n;
      byte_idx <= byte_idx_n;
      csum     <= csum_n;
      shadow   <= shadow_n;
    end
  end

  always_comb begin
    state_n     = state;
    busy_n      = busy;
    done_n      = 1'b0;
    byte_idx_n  = byte_idx;
    csum_n      = csum;
    shadow_n    = shadow;
    ser_start_c = 1'b0;
    ser_data_c  = HEADER;
    load_c      = 1'b0;
    case (state)
      FRAME_IDLE: begin
        if (req) begin
          busy_n = 1'b1;
`ifdef READBACK_SYNC_ALIGN_EN
          state_n = FRAME_ARM;
`else
          load_c  = 1'b1;
`endif
        end
      end
      FRAME_ARM: begin
`ifdef READBACK_SYNC_ALIGN_EN
        load_c  = sync_fall_c;
`else
        state_n = FRAME_IDLE;
`endif
      end
      FRAME_SEND: begin
        if (ser_ready) begin
          if (byte_idx < BYTE_LAST) begin
            byte_idx_n  = byte_nxt_c;
            ser_start_c = 1'b1;
            ser_data_c  = nxt_byte_c;
            if (byte_nxt_c != BYTE_LAST) csum_n = csum + nxt_byte_c;
          end else begin
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = FRAME_IDLE;
          end
        end
      end
      default: state_n = FRAME_IDLE;
    endcase
    // Snapshot and header launch share one path for both acceptance modes.
    if (load_c) begin
      state_n     = FRAME_SEND;
      shadow_n    = snap_c;
      byte_idx_n  = '0;
      csum_n      = '0;
      ser_start_c = 1'b1;
      ser_data_c  = HEADER;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_tx_byte (
    .clk_pll (clk_pll),
    .reset   (reset),
    .start   (ser_start_c),
    .data    (ser_data_c),
    .ready   (ser_ready),
    .txd     (txd)
  );

endmodule

// File: tb/tb_param_readback_tx.sv
// Directed bench for param_readback_tx with 4 clocks per bit; default build (sync align off).
module tb_param_readback_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned BYTEC = 10 * CPB;
  localparam int unsigned NSAMP = 881;

  logic        clk_pll = 1'b0;
  logic        reset, req, sync_on, pu, nut, bl;
  logic [7:0]  per, cp, p_bl;
  logic [15:0] p1wid, del, p2wid, p_bl_off;
  logic [31:0] nut_w, nut_d;
  logic        txd, busy, done;

  int errors = 0;
  int checks = 0;
  int hook_p1wid = -1;
  int hook_req   = -1;

  logic wave  [NSAMP];
  logic busyw [NSAMP];
  logic donew [NSAMP];

  logic [7:0] def_b [22] = '{8'hA5, 8'h01, 8'h00, 8'h1E, 8'h00, 8'hC8, 8'h00, 8'h1E, 8'h00, 8'h00, 8'h00,
                             8'h32, 8'h00, 8'h00, 8'h01, 8'h2C, 8'h01, 8'h32, 8'h00, 8'h64, 8'h07, 8'h02};
  logic [7:0] snap_b [22] = '{8'hA5, 8'h3C, 8'h12, 8'h34, 8'hBE, 8'hEF, 8'h0F, 8'h0F, 8'hDE, 8'hAD, 8'hBE,
                              8'hEF, 8'h01, 8'h02, 8'h03, 8'h04, 8'h80, 8'h7F, 8'hA5, 8'h5A, 8'h05, 8'h92};

  always #5 clk_pll = ~clk_pll;

  param_readback_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_pll (clk_pll), .reset (reset), .req (req), .sync_on (sync_on),
    .per (per), .p1wid (p1wid), .del (del), .p2wid (p2wid), .nut_w (nut_w), .nut_d (nut_d),
    .cp (cp), .p_bl (p_bl), .p_bl_off (p_bl_off), .pu (pu), .nut (nut), .bl (bl),
    .txd (txd), .busy (busy), .done (done)
  );

  // Data byte k from mid-bit samples of the captured line.
  function automatic logic [7:0] wave_byte(int k);
    logic [7:0] r;
    for (int b = 0; b < 8; b++) r[b] = wave[(10 * k + 1 + b) * CPB + 1];
    return r;
  endfunction

  task automatic set_defaults();
    per = 8'd1; p1wid = 16'd30; del = 16'd200; p2wid = 16'd30; nut_w = 32'd50; nut_d = 32'd300;
    cp = 8'd1; p_bl = 8'd50; p_bl_off = 16'd100; pu = 1'b1; nut = 1'b1; bl = 1'b1;
  endtask

  // Ends at the negedge just after the accepting edge (sample index 0).
  task automatic pulse_req();
    @(negedge clk_pll) req = 1'b1;
    @(negedge clk_pll) req = 1'b0;
  endtask

  task automatic capture();
    for (int i = 0; i < int'(NSAMP); i++) begin
      wave[i] = txd; busyw[i] = busy; donew[i] = done;
      if (i == hook_p1wid) p1wid = 16'hFFFF;
      if (hook_req >= 0) req = (i == hook_req);
      @(negedge clk_pll);
    end
  endtask

  task automatic test_reset();
    checks++; if (txd !== 1'b1)  begin errors++; $display("FAIL reset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
  endtask

  task automatic test_defaults();
    int first_done, ndone;
    set_defaults();
    pulse_req();
    capture();
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (wave_byte(k) !== def_b[k]) begin
        errors++; $display("FAIL defaults_byte%0d: got %h want %h", k, wave_byte(k), def_b[k]);
      end
    end
    first_done = -1; ndone = 0;
    for (int i = 0; i < int'(NSAMP); i++)
      if (donew[i] === 1'b1) begin ndone++; if (first_done < 0) first_done = i; end
    checks++; if (first_done != 880) begin errors++; $display("FAIL done_latency: got %0d want 880", first_done); end
    checks++; if (ndone != 1) begin errors++; $display("FAIL done_width: got %0d want 1", ndone); end
    checks++;
    if (busyw[0] !== 1'b1 || busyw[879] !== 1'b1 || busyw[880] !== 1'b0) begin
      errors++; $display("FAIL busy_window: got %b%b%b want 110", busyw[0], busyw[879], busyw[880]);
    end
  endtask

  // Reuses the default-frame capture: every bit exactly CPB samples, 8N1 LSB first.
  task automatic test_bit_timing();
    int bad;
    logic [7:0] v;
    logic want;
    bad = 0;
    for (int i = 0; i < 880; i++) begin
      v = def_b[i / BYTEC];
      case ((i % BYTEC) / CPB)
        0:       want = 1'b0;
        9:       want = 1'b1;
        default: want = v[(i % BYTEC) / CPB - 1];
      endcase
      if (wave[i] !== want) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bit_timing: got %0d bad samples want 0", bad); end
    v = 8'hA5;
    for (int j = 0; j < 10; j++) begin
      want = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : v[j - 1];
      checks++;
      if ({wave[j*CPB], wave[j*CPB+1], wave[j*CPB+2], wave[j*CPB+3]} !== {4{want}}) begin
        errors++; $display("FAIL header_bit%0d: got %b%b%b%b want %b x4", j,
                           wave[j*CPB], wave[j*CPB+1], wave[j*CPB+2], wave[j*CPB+3], want);
      end
    end
    checks++; if (wave[880] !== 1'b1) begin errors++; $display("FAIL idle_after: got %b want 1", wave[880]); end
  endtask

  task automatic test_snapshot();
    int falls, bad;
    per = 8'h3C; p1wid = 16'h1234; del = 16'hBEEF; p2wid = 16'h0F0F; nut_w = 32'hDEADBEEF;
    nut_d = 32'h01020304; cp = 8'h80; p_bl = 8'h7F; p_bl_off = 16'hA55A; pu = 1'b1; nut = 1'b0; bl = 1'b1;
    hook_p1wid = 3 * BYTEC; hook_req = 10 * BYTEC;
    pulse_req();
    capture();
    hook_p1wid = -1; hook_req = -1; req = 1'b0;
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (wave_byte(k) !== snap_b[k]) begin
        errors++; $display("FAIL snapshot_byte%0d: got %h want %h", k, wave_byte(k), snap_b[k]);
      end
    end
    falls = 0;
    for (int i = 1; i < int'(NSAMP); i++) if (busyw[i-1] === 1'b1 && busyw[i] === 1'b0) falls++;
    checks++; if (falls != 1) begin errors++; $display("FAIL busy_falls: got %0d want 1", falls); end
    bad = 0;
    repeat (100) begin
      if (busy !== 1'b0 || txd !== 1'b1) bad++;
      @(negedge clk_pll);
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL no_second_frame: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    set_defaults();
    pulse_req();
    repeat (7 * BYTEC + 1) @(negedge clk_pll);
    checks++; if (txd !== 1'b0) begin errors++; $display("FAIL byte7_start: got %b want 0", txd); end
    reset = 1'b1;
    #1;
    checks++; if (txd !== 1'b1)  begin errors++; $display("FAIL midreset_txd: got %b want 1", txd); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy); end
    repeat (2) @(negedge clk_pll);
    reset = 1'b0;
    @(negedge clk_pll);
    pulse_req();
    capture();
    for (int k = 0; k < 22; k++) begin
      checks++;
      if (wave_byte(k) !== def_b[k]) begin
        errors++; $display("FAIL after_reset_byte%0d: got %h want %h", k, wave_byte(k), def_b[k]);
      end
    end
  endtask

  task automatic test_checksum_wrap();
    int bad;
    per = '1; p1wid = '1; del = '1; p2wid = '1; nut_w = '1; nut_d = '1;
    cp = '1; p_bl = '1; p_bl_off = '1; pu = 1'b1; nut = 1'b1; bl = 1'b1;
    pulse_req();
    capture();
    bad = 0;
    for (int k = 1; k < 20; k++) if (wave_byte(k) !== 8'hFF) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL ones_payload: got %0d wrong bytes want 0", bad); end
    checks++; if (wave_byte(20) !== 8'h07) begin errors++; $display("FAIL ones_flags: got %h want 07", wave_byte(20)); end
    // 19*0xFF + 0x07 = 4852 -> 0xF4
    checks++; if (wave_byte(21) !== 8'hF4) begin errors++; $display("FAIL ones_checksum: got %h want f4", wave_byte(21)); end
  endtask

  task automatic test_back_to_back();
    int n;
    set_defaults();
    @(negedge clk_pll) req = 1'b1;
    @(negedge clk_pll);
    capture();
    checks++; if (wave_byte(21) !== 8'h02) begin errors++; $display("FAIL b2b_checksum: got %h want 02", wave_byte(21)); end
    checks++;
    if (donew[880] !== 1'b1 || busyw[880] !== 1'b0) begin
      errors++; $display("FAIL b2b_end: got done=%b busy=%b want done=1 busy=0", donew[880], busyw[880]);
    end
    checks++;
    if (txd !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL b2b_retrigger: got txd=%b busy=%b want txd=0 busy=1", txd, busy);
    end
    req = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 1000) begin
      @(negedge clk_pll);
      n++;
    end
    checks++; if (n != 880) begin errors++; $display("FAIL b2b_second_done: got %0d want 880", n); end
  endtask

  initial begin
    reset = 1'b1; req = 1'b0; sync_on = 1'b0;
    set_defaults();
    repeat (3) @(negedge clk_pll);
    test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk_pll);
    test_defaults();
    test_bit_timing();
    test_snapshot();
    test_reset_mid();
    test_checksum_wrap();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
